// File: rtl/jtkunio_objbuf.sv
// rtl/jtkunio_objbuf.sv - object line-buffer engine: scan object RAM, fetch ROM, draw, play out
module jtkunio_objbuf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pxl_cen,
    input  logic [8:0]  hdump,
    input  logic [7:0]  vrender,
    input  logic        flip,
    output logic [7:0]  ram_addr,
    input  logic [7:0]  ram_data,
    output logic [16:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [5:0]  pxl
);
    typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAW, NEXT} state_t;

    state_t      state, state_nx;
    logic        bank;
    logic [5:0]  obj_n;
    logic [2:0]  cnt;
    logic        half;
    logic [7:0]  obj_y;
    logic [1:0]  pal;
    logic        hflip;
    logic [10:0] code;
    logic [3:0]  row_f;
    logic        mirror;
    logic [8:0]  xs;
    logic [31:0] gfx;
    logic [5:0]  line_buf [0:511];

    logic        line_start;
    logic        play_bank;
    logic        hit;
    logic        draw_we;
    logic [7:0]  row_now;
    logic [4:0]  ci;
    logic [3:0]  colour;
    logic [8:0]  draw_x;
    logic        attr_unused;

    assign line_start  = pxl_cen && (hdump == 9'd0);
    // On the toggle edge the bank just drawn is already the one being played
    assign play_bank   = line_start ? bank : ~bank;
    assign row_now     = vrender - obj_y;
    assign hit         = row_now < 8'd16;
    assign rom_addr    = {code, half, row_f};
    assign attr_unused = ram_data[4] ^ ram_data[2];

    // State register; reset parks the engine so rom_cs falls at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, ROM request and per-pixel draw decode
    always_comb begin
        state_nx = state;
        rom_cs   = 1'b0;
        ci       = {2'b00, cnt};
        colour   = 4'd0;
        // A mirrored object also swaps its halves so all 16 pixels reverse
        draw_x   = xs + {5'd0, half ^ mirror, 3'd0} + {6'd0, cnt};
        draw_we  = 1'b0;
        case (state)
            IDLE:  state_nx = IDLE;
            SCAN:  if (cnt == 3'd4) state_nx = hit ? FETCH : NEXT;
            FETCH: begin
                rom_cs = 1'b1;
                if (rom_ok) state_nx = DRAW;
            end
            DRAW: begin
                colour = mirror ?
                    {gfx[5'd24 + ci], gfx[5'd16 + ci], gfx[5'd8 + ci], gfx[ci]} :
                    {gfx[5'd31 - ci], gfx[5'd23 - ci], gfx[5'd15 - ci], gfx[5'd7 - ci]};
                draw_we = (colour != 4'd0) && !draw_x[8] && !line_start;
                if (cnt == 3'd7) state_nx = half ? NEXT : FETCH;
            end
            NEXT:    state_nx = (obj_n == 6'd0) ? IDLE : SCAN;
            default: state_nx = IDLE;
        endcase
        if (line_start) state_nx = SCAN;
    end

    // Object scan bookkeeping, attribute capture and bank toggle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank     <= 1'b0;
            obj_n    <= 6'd63;
            cnt      <= 3'd0;
            half     <= 1'b0;
            ram_addr <= 8'd0;
            obj_y    <= 8'd0;
            pal      <= 2'd0;
            hflip    <= 1'b0;
            code     <= 11'd0;
            row_f    <= 4'd0;
            mirror   <= 1'b0;
            xs       <= 9'd0;
            gfx      <= 32'd0;
        end else begin
            if (line_start) bank <= ~bank;
            if (line_start) begin
                obj_n    <= 6'd63;
                cnt      <= 3'd0;
                ram_addr <= {6'd63, 2'b00};
            end else begin
                case (state)
                    SCAN: begin
                        cnt <= cnt + 3'd1;
                        if (cnt < 3'd3) ram_addr <= ram_addr + 8'd1;
                        case (cnt)
                            3'd1: obj_y <= ram_data;
                            3'd2: begin
                                pal        <= ram_data[1:0];
                                hflip      <= ram_data[3];
                                code[10:8] <= ram_data[7:5];
                            end
                            3'd3: code[7:0] <= ram_data;
                            3'd4: begin
                                cnt    <= 3'd0;
                                half   <= 1'b0;
                                row_f  <= row_now[3:0] ^ {4{flip}};
                                mirror <= hflip ^ flip;
                                xs     <= flip ? (9'd240 - {1'b0, ram_data}) : {1'b0, ram_data};
                            end
                            default: ;
                        endcase
                    end
                    FETCH: if (rom_ok) begin
                        gfx <= rom_data;
                        cnt <= 3'd0;
                    end
                    DRAW: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) half <= 1'b1;
                    end
                    NEXT: if (obj_n != 6'd0) begin
                        obj_n    <= obj_n - 6'd1;
                        ram_addr <= {obj_n - 6'd1, 2'b00};
                        cnt      <= 3'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Line buffer: play side erases behind itself, draw side writes the other bank
    always_ff @(posedge clk) begin
        if (pxl_cen && !hdump[8]) line_buf[{play_bank, hdump[7:0]}] <= 6'd0;
        if (draw_we) line_buf[{bank, draw_x[7:0]}] <= {pal, colour};
    end

    // Pixel playout, blank outside the 256 active columns
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pxl <= 6'd0;
        else if (pxl_cen) pxl <= hdump[8] ? 6'd0 : line_buf[{play_bank, hdump[7:0]}];
    end
endmodule

// File: tb/tb_jtkunio_objbuf.sv
// tb/tb_jtkunio_objbuf.sv - directed self-checking bench for jtkunio_objbuf
module tb_jtkunio_objbuf;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pxl_cen = 1'b0;
    logic [8:0]  hdump = 9'd0;
    logic [7:0]  vrender = 8'h25;
    logic        flip = 1'b0;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_data;
    logic [16:0] rom_addr;
    logic        rom_cs;
    logic [31:0] rom_data = 32'd0;
    logic        rom_ok = 1'b0;
    logic [5:0]  pxl;

    int errors = 0;
    int checks = 0;
    int rom_delay = 1;
    logic [7:0]  obj_ram [0:255];
    logic [31:0] rom_mem [int];
    logic [5:0]  line_pix [0:255];
    logic [5:0]  exp_pix [0:255];
    logic [16:0] held_addr;
    logic        stable;

    jtkunio_objbuf dut (
        .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .hdump(hdump),
        .vrender(vrender), .flip(flip), .ram_addr(ram_addr), .ram_data(ram_data),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .pxl(pxl)
    );

    always #5 clk = ~clk;

    // Synchronous object RAM: data one clock after the address
    always @(posedge clk) ram_data <= obj_ram[ram_addr];

    // Video timing: pxl_cen every 4th clk, hdump 0..383
    initial begin : video
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (pxl_cen) hdump = (hdump == 9'd383) ? 9'd0 : hdump + 9'd1;
            ph = (ph + 1) % 4;
            pxl_cen = (ph == 0);
        end
    end

    // ROM: answers after rom_delay clocks of a stable request
    initial begin : rom_model
        int wait_cnt;
        logic last_cs;
        logic [16:0] last_addr;
        wait_cnt = 0;
        last_cs = 1'b0;
        last_addr = 17'd0;
        forever begin
            @(negedge clk);
            if (rom_cs && last_cs && rom_addr == last_addr) wait_cnt++;
            else wait_cnt = 0;
            last_cs = rom_cs;
            last_addr = rom_addr;
            rom_ok = rom_cs && (wait_cnt >= rom_delay);
            rom_data = rom_mem.exists(int'({15'd0, rom_addr})) ? rom_mem[int'({15'd0, rom_addr})] : 32'd0;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_h(input logic [8:0] h);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(pxl_cen && hdump == h) && n < 3000);
        check($sformatf("wait_hdump_%0d", h), 32'(pxl_cen && hdump == h), 32'd1);
    endtask

    task automatic wait_cs(input logic level, input string tag);
        int n;
        n = 0;
        while (rom_cs !== level && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(rom_cs === level), 32'd1);
    endtask

    task automatic capture_line();
        wait_h(9'd0);
        line_pix[0] = pxl;
        for (int h = 1; h < 256; h++) begin
            do tick(); while (!pxl_cen);
            line_pix[hdump[7:0]] = pxl;
        end
    endtask

    task automatic check_line(input string tag);
        for (int h = 0; h < 256; h++)
            check($sformatf("%s_px%0d", tag, h), 32'(line_pix[h]), 32'(exp_pix[h]));
    endtask

    task automatic clear_exp();
        for (int h = 0; h < 256; h++) exp_pix[h] = 6'd0;
    endtask

    task automatic hide_all();
        for (int i = 0; i < 64; i++) obj_ram[4*i] = 8'hF0;
    endtask

    task automatic set_obj(input int i, input logic [7:0] y, input logic [7:0] attr,
                           input logic [7:0] code, input logic [7:0] x);
        obj_ram[4*i]   = y;
        obj_ram[4*i+1] = attr;
        obj_ram[4*i+2] = code;
        obj_ram[4*i+3] = x;
    endtask

    // cols holds 8 colours, pixel 0 in the lowest nibble
    function automatic logic [31:0] pack(input logic [31:0] cols);
        logic [31:0] w;
        logic [3:0] c;
        w = 32'd0;
        for (int i = 0; i < 8; i++) begin
            c = cols[4*i +: 4];
            w[31-i] = c[3];
            w[23-i] = c[2];
            w[15-i] = c[1];
            w[7-i]  = c[0];
        end
        return w;
    endfunction

    function automatic int rom_key(input logic [10:0] code, input logic half, input logic [3:0] row);
        return int'({15'd0, code, half, row});
    endfunction

    initial begin : stim
        for (int i = 0; i < 256; i++) obj_ram[i] = 8'd0;
        hide_all();
        repeat (3) tick();
        check("rst_pxl", 32'(pxl), 32'd0);
        check("rst_rom_cs", 32'(rom_cs), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        rstn = 1'b1;
        wait_h(9'd0);
        wait_h(9'd0);
        wait_h(9'd300);

        // Single object, colour 3 pal 2, row 5
        set_obj(0, 8'h20, 8'h02, 8'h05, 8'h10);
        rom_mem[rom_key(11'd5, 1'b0, 4'd5)] = pack(32'h33333333);
        rom_mem[rom_key(11'd5, 1'b1, 4'd5)] = pack(32'h33333333);
        wait_cs(1'b1, "t1_cs");
        check("t1_rom_addr", 32'(rom_addr), 32'({11'd5, 1'b0, 4'd5}));
        capture_line();
        clear_exp();
        for (int h = 16; h < 32; h++) exp_pix[h] = 6'h23;
        check_line("t1");

        // Overlap: object 0 wins, its transparent pixels show object 1
        wait_h(9'd300);
        hide_all();
        set_obj(0, 8'h20, 8'h01, 8'h0A, 8'h40);
        set_obj(1, 8'h20, 8'h03, 8'h0B, 8'h40);
        rom_mem[rom_key(11'h0A, 1'b0, 4'd5)] = pack(32'h05050505);
        rom_mem[rom_key(11'h0B, 1'b0, 4'd5)] = pack(32'hFFFFFFFF);
        rom_mem[rom_key(11'h0B, 1'b1, 4'd5)] = pack(32'hFFFFFFFF);
        wait_h(9'd0);
        capture_line();
        clear_exp();
        for (int h = 64; h < 80; h++) exp_pix[h] = 6'h3F;
        for (int h = 64; h < 72; h += 2) exp_pix[h] = 6'h15;
        check_line("t2");

        // Right edge with hflip: only 248..255, reversed, no wrap
        wait_h(9'd300);
        hide_all();
        set_obj(0, 8'h20, 8'h09, 8'h0C, 8'hF8);
        rom_mem[rom_key(11'h0C, 1'b0, 4'd5)] = pack(32'h87654321);
        rom_mem[rom_key(11'h0C, 1'b1, 4'd5)] = pack(32'hFEDCBA98);
        wait_h(9'd0);
        capture_line();
        clear_exp();
        for (int j = 0; j < 8; j++) exp_pix[248+j] = 6'h10 | 6'(15 - j);
        check_line("t3");

        // Screen flip: row 3 becomes 12, x = 240 - X, mirrored
        wait_h(9'd300);
        hide_all();
        flip = 1'b1;
        vrender = 8'h23;
        set_obj(0, 8'h20, 8'h01, 8'h0D, 8'h10);
        rom_mem[rom_key(11'h0D, 1'b0, 4'd12)] = pack(32'h87654321);
        rom_mem[rom_key(11'h0D, 1'b1, 4'd12)] = pack(32'hFEDCBA98);
        wait_cs(1'b1, "t4_cs");
        check("t4_rom_addr", 32'(rom_addr), 32'({11'h0D, 1'b0, 4'd12}));
        capture_line();
        clear_exp();
        for (int j = 0; j < 8; j++) exp_pix[224+j] = 6'h10 | 6'(15 - j);
        for (int j = 8; j < 16; j++) exp_pix[224+j] = 6'h10 | 6'(16 - j);
        check_line("t4");

        // Slow ROM: request held stable, then aborted by line start
        wait_h(9'd300);
        hide_all();
        flip = 1'b0;
        vrender = 8'h25;
        set_obj(0, 8'h20, 8'h02, 8'h05, 8'h10);
        rom_delay = 100000;
        wait_cs(1'b1, "t5_cs");
        held_addr = rom_addr;
        check("t5_rom_addr", 32'(rom_addr), 32'({11'd5, 1'b0, 4'd5}));
        stable = 1'b1;
        repeat (500) begin
            tick();
            if (!(rom_cs === 1'b1 && rom_addr === held_addr)) stable = 1'b0;
        end
        check("t5_hold", 32'(stable), 32'd1);
        wait_h(9'd0);
        check("t5_abort_cs", 32'(rom_cs), 32'd0);
        check("t5_restart_addr", 32'(ram_addr), 32'hFC);
        rom_delay = 1;
        tick();
        check("t5_scan_step", 32'(ram_addr), 32'hFD);

        // Reset in the middle of DRAW
        wait_cs(1'b1, "t6_cs_rise");
        wait_cs(1'b0, "t6_cs_fall");
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        check("t6_pxl", 32'(pxl), 32'd0);
        check("t6_rom_cs", 32'(rom_cs), 32'd0);
        check("t6_ram_addr", 32'(ram_addr), 32'd0);
        check("t6_rom_addr", 32'(rom_addr), 32'd0);
        hide_all();
        repeat (3) tick();
        rstn = 1'b1;
        wait_h(9'd0);
        wait_h(9'd0);
        capture_line();
        clear_exp();
        check_line("t6a");
        capture_line();
        check_line("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtkunio_objbuf.md
# jtkunio_objbuf

Object line-buffer engine for the Kunio video path. Scans the 64-entry object RAM for sprites on the next line, fetches their 4bpp graphics from ROM, and draws them into a double line buffer. Plays the buffer out as the 6-bit `obj_pxl` stream consumed by the colour mixer one line later.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; one clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `pxl_cen` in 1: pixel clock enable. `clk` is at least 4× `pxl_cen` rate.
- `hdump` in 9: horizontal counter, 0..383; active pixels are 0..255.
- `vrender` in 8: line being prepared (display line + 1).
- `flip` in 1: screen flip.
- `ram_addr` out 8: object RAM read address. Object n occupies bytes 4n..4n+3.
- `ram_data` in 8: object RAM data, valid 1 clk after `ram_addr`.
- `rom_addr` out 17: `{code[10:0], half, row[3:0]}`.
- `rom_cs` out 1: ROM request.
- `rom_data` in 32: 8 planar 4bpp pixels.
- `rom_ok` in 1: `rom_data` valid for the current `rom_addr`.
- `pxl` out 6: `{pal[1:0], colour[3:0]}`. 0 means transparent.

## Operation
Object byte layout:
- byte0: Y.
- byte1: attr. [1:0] pal, [3] hflip, [7:5] code[10:8].
- byte2: code[7:0].
- byte3: X.

Line start:
- Line start is the `pxl_cen` cycle with `hdump==0`.
- At line start, `bank` toggles. The draw buffer becomes the play buffer.
- The FSM restarts at object 63 for `vrender`, aborting any unfinished work.

FSM:
- IDLE: wait for line start, then go to SCAN.
- SCAN: read bytes 0..3 of object n. Compute `row = vrender - Y` (8-bit, wrapping).
  - If `row < 16`, go to FETCH with `half=0`.
  - Otherwise go to NEXT.
- FETCH: drive `rom_addr` and `rom_cs=1`. Hold both stable until `rom_ok`, then latch `rom_data` and go to DRAW.
  - With `flip`, the row used is `row ^ 15`.
- DRAW: 8 clocks, one pixel per clock.
  - Pixel i (i=0 leftmost) takes bits `{d[31-i], d[23-i], d[15-i], d[7-i]}`, or `d[24+i]`… when mirrored. Mirrored means `hflip ^ flip`.
  - Screen x = `xs + 8*half + i`, 9-bit. With `flip`, `xs = 240 - X`; otherwise `xs = X`.
  - Pixel is written only when colour≠0 and x[8]==0 (no wrap; off-edge pixels are discarded).
  - After `half=0`, return to FETCH with `half=1`. After `half=1`, go to NEXT.
- NEXT: if n==0, go to IDLE; else n←n-1, go to SCAN.

Priority: objects are drawn 63→0 with overwrite, so the lower index wins on overlap.

Playout:
- On each `pxl_cen` with `hdump<256`, `pxl ← play[hdump[7:0]]`, and that entry is cleared to 0 in the same cycle.
- When `hdump≥256`, `pxl←0`.
- Play and draw ports never target the same bank.

## Timing
- Reset values:
  - `pxl=0`, `rom_cs=0`, `ram_addr=0`, `rom_addr=0`.
  - FSM=IDLE, `bank=0`, n=63.
  - Buffer contents are undefined until one full line has been played and erased; the first two lines after reset may show garbage.
- Reset mid-FETCH drops `rom_cs` immediately (asynchronous).
- SCAN: 5 clk per object. FETCH: 1 clk plus ROM wait. DRAW: 8 clk.
- Playout latency: `pxl` for column h is updated at the clk edge of the `pxl_cen` cycle where `hdump==h`.
- Line start during FETCH: `rom_cs` drops on the next clk. The `rom_ok` of the aborted request is ignored.
- Line start coincident with a DRAW write: the write goes to the old draw bank (now the play bank) only if issued before the toggle edge. Writes after the toggle target the new draw bank.

## Test plan
- Object 0 at Y=0x20, X=0x10, code 5, pal 2, all pixels colour 3, `vrender=0x25` → next line: `pxl=0x23` at hdump 16..31 and 0 elsewhere. rom_addr for half 0 is `{11'd5, 0, 4'd5}`.
- Objects 0 and 1 both at X=0x40 with different pals → object 0's pal visible at 64..79. Transparent (colour 0) pixels of object 0 show object 1.
- X=0xF8 → only columns 248..255 drawn, with no wrap into 0..7. hflip=1 reverses the 16-pixel order.
- `flip=1`, X=0x10, row 3 → rom row field =12, pixels at 224..239, mirrored.
- `rom_ok` delayed 500 clk → `rom_cs` and `rom_addr` stay stable. Line start aborts the fetch, and the next line's scan restarts at object 63.
- Assert `rstn` low mid-DRAW → all outputs 0 at once. After release, playout of two lines with no objects gives `pxl=0` everywhere.
